// File: rtl/exec_ctrl_if.sv
// Bundle of the instruction, memory, ALU and result signals of exec_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [1:0]  alusrc;
    logic        branch;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] imm;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic [2:0]  alu_op;
    logic [1:0]  alu_src;
    logic        alu_branch;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_imm;
    logic [15:0] alu_sp;
    logic [15:0] alu_loadval;
    logic [15:0] alu_out;
    logic        alu_branching;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        take_branch;
    logic        err;
    logic [15:0] sp;

    modport slave (
        input  instr_valid, opcode, alusrc, branch, ra, rb, imm,
        input  mem_ack, mem_rdata, alu_out, alu_branching, res_ready,
        output instr_ready, mem_req, mem_addr,
        output alu_op, alu_src, alu_branch, alu_a, alu_b, alu_imm, alu_sp, alu_loadval,
        output res_valid, res_data, take_branch, err, sp
    );

    modport master (
        output instr_valid, opcode, alusrc, branch, ra, rb, imm,
        output mem_ack, mem_rdata, alu_out, alu_branching, res_ready,
        input  instr_ready, mem_req, mem_addr,
        input  alu_op, alu_src, alu_branch, alu_a, alu_b, alu_imm, alu_sp, alu_loadval,
        input  res_valid, res_data, take_branch, err, sp
    );
endinterface

// File: rtl/exec_ctrl.sv
// Execute-stage controller: accepts one instruction, optionally fetches a load
// operand from memory, runs a single ALU cycle and holds the result until taken.
module exec_ctrl #(
    parameter logic [15:0] SP_INIT     = 16'h0000,
    parameter logic [15:0] SP_MAX      = 16'h00FF,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    exec_ctrl_if.slave bus_io
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  src_q;
    logic        br_q;
    logic [15:0] ra_q, rb_q, imm_q;
    logic [15:0] load_q;
    logic [7:0]  tmo_q;
    logic [15:0] sp_q;
    logic [15:0] res_data_q;
    logic        take_q;
    logic        err_q;
    logic [15:0] mem_addr_q;
    logic [15:0] alu_a_q, alu_b_q, alu_imm_q, alu_sp_q, alu_loadval_q;
    logic        accept_s;
    logic        load_expire_s;

    assign accept_s      = (state_q == S_IDLE) && bus_io.instr_valid;
    assign load_expire_s = ((tmo_q + 8'd1) >= MEM_TIMEOUT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ACK arriving on the expiring cycle still wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus_io.instr_valid) begin
                    state_d = (bus_io.opcode == 3'd5) ? S_LOAD : S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bus_io.mem_ack) begin
                    state_d = S_EXEC;
                end else if (load_expire_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_EXEC:  state_d = S_DONE;
            S_DONE: begin
                if (bus_io.res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; ALU control idles at pass-through outside EXEC
    always_comb begin
        bus_io.instr_ready = 1'b0;
        bus_io.mem_req     = 1'b0;
        bus_io.res_valid   = 1'b0;
        bus_io.alu_op      = 3'd7;
        bus_io.alu_src     = 2'd0;
        bus_io.alu_branch  = 1'b0;
        case (state_q)
            S_IDLE: bus_io.instr_ready = 1'b1;
            S_LOAD: bus_io.mem_req     = 1'b1;
            S_EXEC: begin
                bus_io.alu_op     = op_q;
                bus_io.alu_src    = src_q;
                bus_io.alu_branch = br_q;
            end
            S_DONE: bus_io.res_valid = 1'b1;
            default: bus_io.instr_ready = 1'b0;
        endcase
    end

    // Datapath registers: instruction latch, load fetch, ALU operand snapshot, results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= 3'd0;
            src_q         <= 2'd0;
            br_q          <= 1'b0;
            ra_q          <= 16'h0000;
            rb_q          <= 16'h0000;
            imm_q         <= 16'h0000;
            load_q        <= 16'h0000;
            tmo_q         <= 8'd0;
            sp_q          <= SP_INIT;
            res_data_q    <= 16'h0000;
            take_q        <= 1'b0;
            err_q         <= 1'b0;
            mem_addr_q    <= 16'h0000;
            alu_a_q       <= 16'h0000;
            alu_b_q       <= 16'h0000;
            alu_imm_q     <= 16'h0000;
            alu_sp_q      <= 16'h0000;
            alu_loadval_q <= 16'h0000;
        end else begin
            if (accept_s) begin
                op_q  <= bus_io.opcode;
                src_q <= bus_io.alusrc;
                br_q  <= bus_io.branch;
                ra_q  <= bus_io.ra;
                rb_q  <= bus_io.rb;
                imm_q <= bus_io.imm;
                err_q <= 1'b0;
                tmo_q <= 8'd0;
                if (bus_io.opcode == 3'd5) begin
                    mem_addr_q <= bus_io.ra;
                end
            end
            if (state_q == S_LOAD) begin
                if (bus_io.mem_ack) begin
                    load_q <= bus_io.mem_rdata;
                end else begin
                    tmo_q <= tmo_q + 8'd1;
                    if (load_expire_s) begin
                        err_q      <= 1'b1;
                        res_data_q <= 16'hFFFF;
                        take_q     <= 1'b0;
                    end
                end
            end
            // Operands are snapshotted on EXEC entry so they hold afterwards
            if (state_d == S_EXEC) begin
                alu_a_q       <= (state_q == S_IDLE) ? bus_io.ra  : ra_q;
                alu_b_q       <= (state_q == S_IDLE) ? bus_io.rb  : rb_q;
                alu_imm_q     <= (state_q == S_IDLE) ? bus_io.imm : imm_q;
                alu_sp_q      <= sp_q;
                alu_loadval_q <= (state_q == S_LOAD) ? bus_io.mem_rdata : load_q;
            end
            if (state_q == S_EXEC) begin
                if ((op_q == 3'd6) && (sp_q == SP_MAX)) begin
                    err_q      <= 1'b1;
                    res_data_q <= sp_q;
                    take_q     <= 1'b0;
                end else begin
                    res_data_q <= bus_io.alu_out;
                    take_q     <= bus_io.alu_branching;
                    if (op_q == 3'd6) begin
                        sp_q <= bus_io.alu_out;
                    end
                end
            end
        end
    end

    assign bus_io.mem_addr    = mem_addr_q;
    assign bus_io.alu_a       = alu_a_q;
    assign bus_io.alu_b       = alu_b_q;
    assign bus_io.alu_imm     = alu_imm_q;
    assign bus_io.alu_sp      = alu_sp_q;
    assign bus_io.alu_loadval = alu_loadval_q;
    assign bus_io.res_data    = res_data_q;
    assign bus_io.take_branch = take_q;
    assign bus_io.err         = err_q;
    assign bus_io.sp          = sp_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural ALU model driving ALU_OUT.
module tb_exec_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   req_cycles;
    int   lat;

    exec_ctrl_if bus ();

    exec_ctrl #(
        .SP_INIT    (16'h0000),
        .SP_MAX     (16'h0002),
        .MEM_TIMEOUT(8'd16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    logic [15:0] opb_s;
    logic [15:0] alu_res_s;
    always_comb begin
        case (bus.alu_src)
            2'd0:    opb_s = bus.alu_b;
            2'd1:    opb_s = bus.alu_imm;
            2'd2:    opb_s = bus.alu_loadval;
            default: opb_s = bus.alu_sp;
        endcase
        case (bus.alu_op)
            3'd0:    alu_res_s = bus.alu_a + opb_s;
            3'd1:    alu_res_s = bus.alu_a - opb_s;
            3'd2:    alu_res_s = {15'd0, bus.alu_a[0]};
            3'd3:    alu_res_s = opb_s;
            3'd4:    alu_res_s = bus.alu_a << opb_s[3:0];
            3'd5:    alu_res_s = bus.alu_loadval + opb_s;
            3'd6:    alu_res_s = bus.alu_sp + 16'd1;
            default: alu_res_s = bus.alu_a;
        endcase
        bus.alu_out       = alu_res_s;
        bus.alu_branching = bus.alu_branch && (alu_res_s == 16'h0000);
    end

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  src;
        logic        br;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] imm;
        logic [15:0] exp_data;
        logic        exp_take;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and wait for RES_VALID; ack_at = edge after accept that sees MEM_ACK
    task automatic issue(input logic [2:0] op, input logic [1:0] src, input logic br,
                         input logic [15:0] ra, input logic [15:0] rb, input logic [15:0] imm,
                         input int ack_at, output int lat_o);
        chk("instr_ready_before_issue", {15'd0, bus.instr_ready}, 16'd1);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.alusrc      = src;
        bus.branch      = br;
        bus.ra          = ra;
        bus.rb          = rb;
        bus.imm         = imm;
        tick();
        bus.instr_valid = 1'b0;
        lat_o      = 0;
        req_cycles = 0;
        while (!bus.res_valid && lat_o < 100) begin
            bus.mem_ack = (lat_o + 1 == ack_at);
            if (bus.mem_req) begin
                req_cycles++;
                chk("mem_addr_during_req", bus.mem_addr, ra);
            end
            chk("instr_ready_busy", {15'd0, bus.instr_ready}, 16'd0);
            tick();
            lat_o++;
        end
        bus.mem_ack = 1'b0;
        chk("res_valid_reached", {15'd0, bus.res_valid}, 16'd1);
    endtask

    task automatic release_ok();
        tick();
        chk("res_valid_after_handshake", {15'd0, bus.res_valid}, 16'd0);
        chk("instr_ready_after_handshake", {15'd0, bus.instr_ready}, 16'd1);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = 3'd0;
        bus.alusrc      = 2'd0;
        bus.branch      = 1'b0;
        bus.ra          = 16'h0000;
        bus.rb          = 16'h0000;
        bus.imm         = 16'h0000;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 16'h0000;
        bus.res_ready   = 1'b1;

        vecs[0] = '{3'd0, 2'd0, 1'b0, 16'd5,    16'd7, 16'd0,     16'd12,    1'b0};
        vecs[1] = '{3'd1, 2'd0, 1'b1, 16'd3,    16'd3, 16'd0,     16'd0,     1'b1};
        vecs[2] = '{3'd1, 2'd0, 1'b1, 16'd3,    16'd5, 16'd0,     16'hFFFE,  1'b0};
        vecs[3] = '{3'd0, 2'd1, 1'b0, 16'hFFFF, 16'd0, 16'd1,     16'h0000,  1'b0};
        vecs[4] = '{3'd2, 2'd0, 1'b0, 16'h0003, 16'd0, 16'd0,     16'h0001,  1'b0};
        vecs[5] = '{3'd3, 2'd1, 1'b0, 16'h0000, 16'd0, 16'h1234,  16'h1234,  1'b0};
        vecs[6] = '{3'd4, 2'd0, 1'b0, 16'h0001, 16'd4, 16'd0,     16'h0010,  1'b0};
        vecs[7] = '{3'd7, 2'd0, 1'b0, 16'hBEEF, 16'd0, 16'd0,     16'hBEEF,  1'b0};

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_instr_ready", {15'd0, bus.instr_ready}, 16'd1);
        chk("rst_res_valid",   {15'd0, bus.res_valid},   16'd0);
        chk("rst_res_data",    bus.res_data,             16'h0000);
        chk("rst_take_branch", {15'd0, bus.take_branch}, 16'd0);
        chk("rst_err",         {15'd0, bus.err},         16'd0);
        chk("rst_mem_req",     {15'd0, bus.mem_req},     16'd0);
        chk("rst_mem_addr",    bus.mem_addr,             16'h0000);
        chk("rst_sp",          bus.sp,                   16'h0000);
        chk("idle_alu_op",     {13'd0, bus.alu_op},      16'd7);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].src, vecs[i].br, vecs[i].ra, vecs[i].rb, vecs[i].imm, 0, lat);
            chk($sformatf("vec%0d_latency", i), lat[15:0], 16'd1);
            chk($sformatf("vec%0d_res_data", i), bus.res_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_take", i), {15'd0, bus.take_branch}, {15'd0, vecs[i].exp_take});
            chk($sformatf("vec%0d_err", i), {15'd0, bus.err}, 16'd0);
            release_ok();
        end

        // Load with ACK on the third LOAD edge
        bus.mem_rdata = 16'd10;
        issue(3'd5, 2'd1, 1'b0, 16'h0040, 16'd0, 16'd2, 3, lat);
        chk("load_latency",  lat[15:0],        16'd4);
        chk("load_req_cyc",  req_cycles[15:0], 16'd3);
        chk("load_res_data", bus.res_data,     16'd12);
        chk("load_err",      {15'd0, bus.err}, 16'd0);
        release_ok();

        // Timeout: no ACK at all
        issue(3'd5, 2'd1, 1'b0, 16'h0050, 16'd0, 16'd2, 0, lat);
        chk("tmo_req_cycles", req_cycles[15:0],         16'd16);
        chk("tmo_err",        {15'd0, bus.err},         16'd1);
        chk("tmo_res_data",   bus.res_data,             16'hFFFF);
        chk("tmo_take",       {15'd0, bus.take_branch}, 16'd0);
        release_ok();
        issue(3'd0, 2'd0, 1'b0, 16'd1, 16'd2, 16'd0, 0, lat);
        chk("err_cleared",    {15'd0, bus.err},         16'd0);
        chk("after_tmo_data", bus.res_data,             16'd3);
        release_ok();

        // ACK on the very cycle the counter expires
        bus.mem_rdata = 16'h0100;
        issue(3'd5, 2'd1, 1'b0, 16'h0060, 16'd0, 16'd5, 16, lat);
        chk("ack16_err",     {15'd0, bus.err}, 16'd0);
        chk("ack16_data",    bus.res_data,     16'h0105);
        chk("ack16_latency", lat[15:0],        16'd17);
        release_ok();

        // Stack pushes against SP_MAX=2
        for (int i = 1; i <= 3; i++) begin
            issue(3'd6, 2'd0, 1'b0, 16'd0, 16'd0, 16'd0, 0, lat);
            chk($sformatf("push%0d_sp", i), bus.sp, (i < 3) ? 16'(i) : 16'd2);
            chk($sformatf("push%0d_err", i), {15'd0, bus.err}, (i < 3) ? 16'd0 : 16'd1);
            chk($sformatf("push%0d_data", i), bus.res_data, (i < 3) ? 16'(i) : 16'd2);
            release_ok();
        end

        // Back-pressure holds DONE
        bus.res_ready = 1'b0;
        issue(3'd0, 2'd0, 1'b0, 16'd1, 16'd1, 16'd0, 0, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_res_valid",   {15'd0, bus.res_valid},   16'd1);
            chk("bp_instr_ready", {15'd0, bus.instr_ready}, 16'd0);
            chk("bp_res_data",    bus.res_data,             16'd2);
        end
        bus.res_ready = 1'b1;
        release_ok();

        // Reset while waiting in LOAD
        bus.instr_valid = 1'b1;
        bus.opcode      = 3'd5;
        bus.ra          = 16'h0080;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("preload_mem_req", {15'd0, bus.mem_req}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstload_mem_req",     {15'd0, bus.mem_req},     16'd0);
        chk("rstload_instr_ready", {15'd0, bus.instr_ready}, 16'd1);
        chk("rstload_sp",          bus.sp,                   16'h0000);
        repeat (3) begin
            tick();
            chk("rstload_no_result", {15'd0, bus.res_valid}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
